// File: rtl/dsp_sched_pkg.sv
// Shared types for the 4-lane SIMD adder scheduler.
// Lane tags travel alongside the DSP pipeline to route sums home.
package dsp_sched_pkg;

    localparam int LANES = 4;

    typedef struct packed {
        logic       vld;
        logic [3:0] id;
    } lane_tag_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: grants up to four requesters per cycle,
// starting the scan at ptr and packing them into lanes 0..3.
module rr_pick4
    import dsp_sched_pkg::*;
#(
    parameter int NREQ = 8,
    parameter int PW   = 3
) (
    input  logic [NREQ-1:0]       req,
    input  logic [PW-1:0]         ptr,
    output logic [NREQ-1:0]       grant,
    output logic [LANES-1:0][3:0] lane_id,
    output logic [LANES-1:0]      lane_vld,
    output logic [PW-1:0]         next_ptr
);

    int idx;
    int cnt;

    always_comb begin
        grant    = '0;
        lane_id  = '0;
        lane_vld = '0;
        next_ptr = ptr;
        idx      = 0;
        cnt      = 0;
        for (int s = 0; s < NREQ; s++) begin
            idx = int'(ptr) + s;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx] && cnt < LANES) begin
                grant[idx]    = 1'b1;
                lane_id[cnt]  = 4'(idx);
                lane_vld[cnt] = 1'b1;
                cnt           = cnt + 1;
                next_ptr      = PW'((idx + 1 == NREQ) ? 0 : idx + 1);
            end
        end
    end

endmodule

// File: rtl/dsp_add_v4_sched.sv
// Shares one 4-lane DSP adder among NREQ scalar requesters,
// tracking lane ownership through the DSP latency.
module dsp_add_v4_sched
    import dsp_sched_pkg::*;
#(
    parameter int NREQ  = 8,
    parameter int WIDTH = 12,
    parameter int LAT   = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [NREQ*WIDTH-1:0]   rsp_y,
    output logic [LANES*WIDTH-1:0]  dsp_a,
    output logic [LANES*WIDTH-1:0]  dsp_b,
    input  logic [LANES*WIDTH-1:0]  dsp_y,
    output logic                    busy
);

    localparam int PW = clog2(NREQ);

    logic [PW-1:0]              ptr;
    logic [PW-1:0]              next_ptr;
    logic [NREQ-1:0]            grant;
    logic [LANES-1:0][3:0]      lane_id;
    logic [LANES-1:0]           lane_vld;
    logic [LANES-1:0][WIDTH-1:0] lane_a;
    logic [LANES-1:0][WIDTH-1:0] lane_b;
    lane_tag_t [LANES-1:0]      iss_tag;
    lane_tag_t [LANES-1:0]      aln_tag;
    logic                       pipe_busy;

    rr_pick4 #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req      (req_valid & {NREQ{en & reset_n}}),
        .ptr      (ptr),
        .grant    (grant),
        .lane_id  (lane_id),
        .lane_vld (lane_vld),
        .next_ptr (next_ptr)
    );

    assign req_ready = grant;

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_vld[k]) begin
                lane_a[k] = req_a[int'(lane_id[k])*WIDTH +: WIDTH];
                lane_b[k] = req_b[int'(lane_id[k])*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            dsp_a   <= '0;
            dsp_b   <= '0;
            iss_tag <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                dsp_a[k*WIDTH +: WIDTH] <= lane_a[k];
                dsp_b[k*WIDTH +: WIDTH] <= lane_b[k];
                iss_tag[k].vld          <= lane_vld[k];
                iss_tag[k].id           <= lane_id[k];
            end
            if (|grant) ptr <= next_ptr;
        end
    end

    // Tags ride LAT stages behind the issue register, matching dsp_y.
    generate
        if (LAT == 0) begin : g_nopipe
            assign aln_tag   = iss_tag;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            lane_tag_t [LANES-1:0] tag_pipe [LAT];
            logic any_vld;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
                end else begin
                    tag_pipe[0] <= iss_tag;
                    for (int i = 1; i < LAT; i++)
                        tag_pipe[i] <= tag_pipe[i-1];
                end
            end

            always_comb begin
                any_vld = 1'b0;
                for (int i = 0; i < LAT; i++)
                    for (int k = 0; k < LANES; k++)
                        any_vld = any_vld | tag_pipe[i][k].vld;
            end

            assign aln_tag   = tag_pipe[LAT-1];
            assign pipe_busy = any_vld;
        end
    endgenerate

    always_comb begin
        busy = pipe_busy;
        for (int k = 0; k < LANES; k++)
            busy = busy | iss_tag[k].vld;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_y     <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_y     <= '0;
            for (int k = 0; k < LANES; k++) begin
                if (aln_tag[k].vld) begin
                    rsp_valid[int'(aln_tag[k].id)] <= 1'b1;
                    rsp_y[int'(aln_tag[k].id)*WIDTH +: WIDTH] <=
                        dsp_y[k*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_add_v4_sched.sv
// Bench for dsp_add_v4_sched: behavioural DSP adder, a round-robin
// reference model and per-requester result queues.
module tb_dsp_add_v4_sched;

    localparam int NREQ  = 8;
    localparam int W     = 12;
    localparam int LAT   = 2;

    typedef struct {
        logic [W-1:0] y;
        int           due;
    } exp_t;

    logic              clock;
    logic              reset_n;
    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ*W-1:0] rsp_y;
    logic [4*W-1:0]    dsp_a;
    logic [4*W-1:0]    dsp_b;
    logic [4*W-1:0]    dsp_y;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mptr   = 0;
    exp_t sb [NREQ][$];
    logic [4*W-1:0] dp [LAT];

    dsp_add_v4_sched #(.NREQ(NREQ), .WIDTH(W), .LAT(LAT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .dsp_a     (dsp_a),
        .dsp_b     (dsp_b),
        .dsp_y     (dsp_y),
        .busy      (busy)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    // External DSP wrapper: independent lanes, LAT cycles deep.
    always @(posedge clock) begin
        for (int k = 0; k < 4; k++)
            dp[0][k*W +: W] <= dsp_a[k*W +: W] + dsp_b[k*W +: W];
        for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
    end
    assign dsp_y = dp[LAT-1];

    function automatic logic [NREQ-1:0] pick(
        input logic [NREQ-1:0] v, input int p, output int np);
        logic [NREQ-1:0] g;
        int n;
        int i;
        g  = '0;
        n  = 0;
        np = p;
        for (int s = 0; s < NREQ; s++) begin
            i = (p + s) % NREQ;
            if (v[i] && n < 4) begin
                g[i] = 1'b1;
                n++;
                np = (i + 1) % NREQ;
            end
        end
        return g;
    endfunction

    always @(negedge clock) begin
        logic [NREQ-1:0] g;
        int np;
        exp_t e;
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) sb[i].delete();
            mptr = 0;
            checks++;
            if (req_ready !== '0 || rsp_valid !== '0 || rsp_y !== '0 ||
                dsp_a !== '0 || dsp_b !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: ready=%h rv=%h dsp_a=%h busy=%b, required all 0",
                         req_ready, rsp_valid, dsp_a, busy);
            end
        end else begin
            np = mptr;
            g = en ? pick(req_valid, mptr, np) : '0;
            checks++;
            if (req_ready !== g) begin
                errors++;
                $display("FAIL grant cyc=%0d: got %h, required %h",
                         cyc, req_ready, g);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    e.y   = req_a[i*W +: W] + req_b[i*W +: W];
                    e.due = cyc + LAT + 2;
                    sb[i].push_back(e);
                end
            end
            if (g != '0) mptr = np;
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i]) begin
                    checks++;
                    if (sb[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp req%0d cyc=%0d: y=%h, required no pulse",
                                 i, cyc, rsp_y[i*W +: W]);
                    end else begin
                        e = sb[i].pop_front();
                        if (rsp_y[i*W +: W] !== e.y || cyc != e.due) begin
                            errors++;
                            $display("FAIL rsp req%0d: y=%h cyc=%0d, required y=%h cyc=%0d",
                                     i, rsp_y[i*W +: W], cyc, e.y, e.due);
                        end
                    end
                end else begin
                    if (rsp_y[i*W +: W] !== '0) begin
                        errors++;
                        $display("FAIL rsp_hold req%0d: y=%h, required 0",
                                 i, rsp_y[i*W +: W]);
                    end
                    if (sb[i].size() != 0 && sb[i][0].due <= cyc) begin
                        errors++;
                        e = sb[i].pop_front();
                        $display("FAIL missing_rsp req%0d cyc=%0d: none, required y=%h",
                                 i, cyc, e.y);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 0;
        en        = 1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(negedge clock);
        checks++;
        if (req_ready !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: ready=%h busy=%b, required 0 0",
                     req_ready, busy);
        end
        @(posedge clock);
        #1;
        reset_n   = 1;
        req_valid = '0;
        tick(2);
    endtask

    task automatic test_full_load();
        logic [NREQ-1:0] expg;
        for (int c = 0; c < 6; c++) begin
            req_valid = '1;
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*W +: W] = W'($urandom);
                req_b[i*W +: W] = W'($urandom);
            end
            expg = (c % 2 == 0) ? 8'h0F : 8'hF0;
            @(negedge clock);
            checks++;
            if (req_ready !== expg) begin
                errors++;
                $display("FAIL full_load c=%0d: ready=%h, required %h",
                         c, req_ready, expg);
            end
            tick(1);
        end
        req_valid = '0;
        tick(6);
    endtask

    task automatic test_single();
        req_valid = 8'h01;
        req_a[0 +: W] = 12'd5;
        req_b[0 +: W] = 12'd7;
        @(negedge clock);
        checks++;
        if (req_ready !== 8'h01) begin
            errors++;
            $display("FAIL single_ready: ready=%h, required 01", req_ready);
        end
        tick(1);
        req_valid = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (rsp_valid !== 8'h01 || rsp_y[0 +: W] !== 12'd12) begin
            errors++;
            $display("FAIL single_rsp: rv=%h y=%0d, required 01 12",
                     rsp_valid, rsp_y[0 +: W]);
        end
        tick(4);
    endtask

    task automatic test_wrap();
        logic [4*W-1:0] lanes;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(12'h100 + i);
            req_b[i*W +: W] = W'(12'h020 + i);
        end
        req_valid = 8'h20;
        tick(1);
        req_valid = 8'hC3;
        @(negedge clock);
        checks++;
        if (req_ready !== 8'hC3) begin
            errors++;
            $display("FAIL wrap_ready: ready=%h, required c3", req_ready);
        end
        tick(1);
        req_valid = 8'hFF;
        lanes = {12'h101, 12'h100, 12'h107, 12'h106};
        @(negedge clock);
        checks++;
        if (dsp_a !== lanes) begin
            errors++;
            $display("FAIL wrap_lanes: dsp_a=%h, required %h", dsp_a, lanes);
        end
        checks++;
        if (req_ready !== 8'h3C) begin
            errors++;
            $display("FAIL wrap_next_ptr: ready=%h, required 3c", req_ready);
        end
        tick(1);
        req_valid = '0;
        tick(6);
    endtask

    task automatic test_lane_arith();
        req_a[0*W +: W] = 12'h7FF; req_b[0*W +: W] = 12'h001;
        req_a[1*W +: W] = 12'hFFF; req_b[1*W +: W] = 12'h002;
        req_a[2*W +: W] = 12'h123; req_b[2*W +: W] = 12'h456;
        req_a[3*W +: W] = 12'hFFF; req_b[3*W +: W] = 12'hFFF;
        req_valid = 8'h0F;
        tick(1);
        req_valid = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (rsp_valid !== 8'h0F || rsp_y[4*W-1:0] !== 48'hFFE_579_001_800) begin
            errors++;
            $display("FAIL lane_arith: rv=%h y=%h, required 0f ffe579001800",
                     rsp_valid, rsp_y[4*W-1:0]);
        end
        tick(4);
    endtask

    task automatic test_enable();
        en = 1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
        end
        tick(1);
        en = 0;
        @(negedge clock);
        checks++;
        if (req_ready !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL en_off: ready=%h busy=%b, required 00 1",
                     req_ready, busy);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_inflight: busy=%b, required 1", busy);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 8'hF0) begin
            errors++;
            $display("FAIL drain: busy=%b rv=%h, required 0 f0",
                     busy, rsp_valid);
        end
        tick(1);
        req_valid = '0;
        en = 1;
        tick(4);
    endtask

    task automatic test_reset_mid();
        req_valid = 8'h01;
        req_a[0 +: W] = 12'h00A;
        req_b[0 +: W] = 12'h00B;
        tick(1);
        reset_n   = 0;
        req_valid = '0;
        @(negedge clock);
        checks++;
        if (dsp_a !== '0 || busy !== 1'b0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL mid_reset: dsp_a=%h busy=%b rv=%h, required 0",
                     dsp_a, busy, rsp_valid);
        end
        tick(1);
        reset_n   = 1;
        req_valid = '1;
        @(negedge clock);
        checks++;
        if (req_ready !== 8'h0F) begin
            errors++;
            $display("FAIL post_reset_ptr: ready=%h, required 0f", req_ready);
        end
        tick(1);
        req_valid = '0;
        tick(8);
    endtask

    task automatic test_final_drain();
        int left;
        left = 0;
        for (int i = 0; i < NREQ; i++) left += sb[i].size();
        checks++;
        if (left != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL final_drain: pending=%0d busy=%b, required 0 0",
                     left, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_single();
        test_wrap();
        test_lane_arith();
        test_enable();
        test_reset_mid();
        test_final_drain();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
